// File: rtl/sdr_mac_pkg.sv
// Shared types and constants for the SDR MAC transmit path.
package sdr_mac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PASS  = 2'b01,
        DRAIN = 2'b10
    } tx_state_e;

    localparam int unsigned MAX_NUM_SRC     = 4;
    localparam int unsigned STD_MAX_PKT_LEN = 1518;

    // Saturating add of a small increment onto a 16-bit statistics counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] cnt, input logic [2:0] inc);
        logic [16:0] sum;
        sum = {1'b0, cnt} + {14'd0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/mac_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester strictly after ptr_i, wrapping.
module rr_pick
    import sdr_mac_pkg::*;
#(
    parameter int unsigned NUM_SRC = 2
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [1:0]         ptr_i,
    output logic [1:0]         gnt_o,
    output logic               any_o
);

    always_comb begin
        int unsigned idx;
        gnt_o = '0;
        any_o = 1'b0;
        for (int unsigned k = 1; k <= NUM_SRC; k++) begin
            idx = (32'(ptr_i) + k) % NUM_SRC;
            if (!any_o && req_i[idx]) begin
                any_o = 1'b1;
                gnt_o = idx[1:0];
            end
        end
    end

endmodule

// File: rtl/mac_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing the MAC transmit byte stream between sources.
// Granted packets pass through combinationally; oversize packets are truncated and drained.
module mac_tx_arbiter
    import sdr_mac_pkg::*;
#(
    parameter int unsigned NUM_SRC     = 2,
    parameter int unsigned MAX_PKT_LEN = STD_MAX_PKT_LEN
) (
    input  logic                   tx_clk,
    input  logic                   rst,
    input  logic [8*NUM_SRC-1:0]   src_data,
    input  logic [NUM_SRC-1:0]     src_sop,
    input  logic [NUM_SRC-1:0]     src_eop,
    input  logic [NUM_SRC-1:0]     src_valid,
    output logic [NUM_SRC-1:0]     src_rdy,
    output logic [7:0]             mac_data,
    output logic                   mac_sop,
    output logic                   mac_eop,
    output logic                   mac_err,
    output logic                   mac_wren,
    input  logic                   mac_rdy,
    output logic [1:0]             grant_id,
    output logic                   busy,
    output logic [15:0]            trunc_count,
    output logic [15:0]            flush_count
);

    localparam int unsigned CNT_W = $clog2(MAX_PKT_LEN);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_PKT_LEN - 1);

    tx_state_e          state_q, state_d;
    logic [1:0]         rr_ptr_q, rr_ptr_d;
    logic [1:0]         grant_q, grant_d;
    logic [CNT_W-1:0]   beat_q, beat_d;
    logic [15:0]        trunc_q, trunc_d;
    logic [15:0]        flush_q, flush_d;

    logic [NUM_SRC-1:0] gnt_oh;
    logic [7:0]         sel_data;
    logic               sel_valid, sel_sop, sel_eop;
    logic [1:0]         pick_gnt;
    logic               pick_any;
    logic [NUM_SRC-1:0] flush_mask;
    logic [2:0]         flush_n;
    logic               xfer, at_limit;

    rr_pick #(
        .NUM_SRC (NUM_SRC)
    ) u_pick (
        .req_i (src_valid & src_sop),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt),
        .any_o (pick_any)
    );

    always_comb begin
        gnt_oh    = '0;
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_sop   = 1'b0;
        sel_eop   = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (grant_q == 2'(i)) begin
                gnt_oh[i] = 1'b1;
                sel_data  = src_data[8*i +: 8];
                sel_valid = src_valid[i];
                sel_sop   = src_sop[i];
                sel_eop   = src_eop[i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        beat_d   = beat_q;
        trunc_d  = trunc_q;
        flush_d  = flush_q;
        src_rdy  = '0;
        mac_data = '0;
        mac_sop  = 1'b0;
        mac_eop  = 1'b0;
        mac_err  = 1'b0;
        mac_wren = 1'b0;
        xfer     = 1'b0;
        at_limit = 1'b0;
        flush_mask = src_valid & ~src_sop;
        flush_n  = '0;

        unique case (state_q)
            IDLE: begin
                // Requesters carry sop, so the flush set never includes the grantee.
                src_rdy = flush_mask;
                for (int unsigned i = 0; i < NUM_SRC; i++) begin
                    flush_n = flush_n + 3'(flush_mask[i]);
                end
                flush_d = sat_inc16(flush_q, flush_n);
                if (pick_any) begin
                    grant_d  = pick_gnt;
                    rr_ptr_d = pick_gnt;
                    beat_d   = '0;
                    state_d  = PASS;
                end
            end
            PASS: begin
                xfer     = sel_valid & mac_rdy;
                at_limit = (beat_q == LAST_BEAT) & ~sel_eop;
                src_rdy  = gnt_oh & {NUM_SRC{mac_rdy}};
                mac_data = sel_data;
                mac_sop  = sel_sop;
                mac_eop  = sel_eop | (xfer & at_limit);
                mac_err  = xfer & at_limit;
                mac_wren = xfer;
                if (xfer) begin
                    beat_d = beat_q + 1'b1;
                    if (sel_eop) begin
                        state_d = IDLE;
                    end else if (at_limit) begin
                        trunc_d = sat_inc16(trunc_q, 3'd1);
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                src_rdy = gnt_oh;
                if (sel_valid && sel_eop) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (rst) begin
            src_rdy  = '0;
            mac_data = '0;
            mac_sop  = 1'b0;
            mac_eop  = 1'b0;
            mac_err  = 1'b0;
            mac_wren = 1'b0;
        end
    end

    always_ff @(posedge tx_clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= 2'(NUM_SRC - 1);
            grant_q  <= '0;
            beat_q   <= '0;
            trunc_q  <= '0;
            flush_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            beat_q   <= beat_d;
            trunc_q  <= trunc_d;
            flush_q  <= flush_d;
        end
    end

    assign grant_id    = grant_q;
    assign busy        = (state_q != IDLE);
    assign trunc_count = trunc_q;
    assign flush_count = flush_q;

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Bench for mac_tx_arbiter: two instances (default and 16-byte limit) on shared sources,
// checked every cycle against a packet-level reference model plus directed literal checks.
`timescale 1ns/1ps
module tb_mac_tx_arbiter;

    localparam int N    = 2;
    localparam int MAXA = 1518;
    localparam int MAXB = 16;

    typedef struct packed { logic [7:0] d; logic s; logic e; } beat_t;
    typedef struct { bit pkt; bit drop; int g; int ptr; int cnt; int gid; int trunc; int flush; } mstate_t;
    typedef struct { logic [N-1:0] rdy; logic [7:0] data; logic sop; logic eop; logic err; logic wren; } mexp_t;

    logic tx_clk = 1'b0;
    always #5 tx_clk = ~tx_clk;

    logic           rst       = 1'b1;
    logic [8*N-1:0] src_data  = '0;
    logic [N-1:0]   src_sop   = '0;
    logic [N-1:0]   src_eop   = '0;
    logic [N-1:0]   src_valid = '0;
    logic           mac_rdy   = 1'b0;

    logic [N-1:0] a_src_rdy, b_src_rdy;
    logic [7:0]   a_mac_data, b_mac_data;
    logic         a_mac_sop, a_mac_eop, a_mac_err, a_mac_wren, a_busy;
    logic         b_mac_sop, b_mac_eop, b_mac_err, b_mac_wren, b_busy;
    logic [1:0]   a_grant_id, b_grant_id;
    logic [15:0]  a_trunc, a_flush, b_trunc, b_flush;

    mac_tx_arbiter #(.NUM_SRC(N), .MAX_PKT_LEN(MAXA)) dut_a (
        .tx_clk(tx_clk), .rst(rst), .src_data(src_data), .src_sop(src_sop), .src_eop(src_eop),
        .src_valid(src_valid), .src_rdy(a_src_rdy), .mac_data(a_mac_data), .mac_sop(a_mac_sop),
        .mac_eop(a_mac_eop), .mac_err(a_mac_err), .mac_wren(a_mac_wren), .mac_rdy(mac_rdy),
        .grant_id(a_grant_id), .busy(a_busy), .trunc_count(a_trunc), .flush_count(a_flush));

    mac_tx_arbiter #(.NUM_SRC(N), .MAX_PKT_LEN(MAXB)) dut_b (
        .tx_clk(tx_clk), .rst(rst), .src_data(src_data), .src_sop(src_sop), .src_eop(src_eop),
        .src_valid(src_valid), .src_rdy(b_src_rdy), .mac_data(b_mac_data), .mac_sop(b_mac_sop),
        .mac_eop(b_mac_eop), .mac_err(b_mac_err), .mac_wren(b_mac_wren), .mac_rdy(mac_rdy),
        .grant_id(b_grant_id), .busy(b_busy), .trunc_count(b_trunc), .flush_count(b_flush));

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- source queues and driver ----------------
    beat_t q0[$];
    beat_t q1[$];
    bit          rst_req    = 1'b1;
    int          rdy_mode   = 0;
    bit          gap_en     = 1'b0;
    logic [N-1:0] stray_mask = '0;
    logic [N-1:0] pres       = '0;
    logic [N-1:0] cons       = '0;

    function automatic int qsize(input int s);
        return (s == 0) ? q0.size() : q1.size();
    endfunction

    function automatic beat_t qhead(input int s);
        return (s == 0) ? q0[0] : q1[0];
    endfunction

    task automatic qpop(input int s);
        beat_t b;
        if (s == 0 && q0.size() > 0) b = q0.pop_front();
        if (s == 1 && q1.size() > 0) b = q1.pop_front();
    endtask

    task automatic qpush(input int s, input beat_t b);
        if (s == 0) q0.push_back(b);
        else q1.push_back(b);
    endtask

    always @(posedge tx_clk) begin
        #1;
        for (int s = 0; s < N; s++) if (pres[s] && cons[s]) qpop(s);
        rst = rst_req;
        case (rdy_mode)
            0:       mac_rdy = 1'b1;
            1:       mac_rdy = ~mac_rdy;
            2:       mac_rdy = ($urandom_range(0, 3) != 0);
            default: mac_rdy = 1'b0;
        endcase
        for (int s = 0; s < N; s++) begin
            beat_t b;
            pres[s]            = 1'b0;
            src_valid[s]       = 1'b0;
            src_data[8*s +: 8] = 8'($urandom);
            src_sop[s]         = 1'($urandom);
            src_eop[s]         = 1'($urandom);
            if (stray_mask[s]) begin
                src_valid[s] = 1'b1;
                src_sop[s]   = 1'b0;
                src_eop[s]   = 1'b0;
            end else if (qsize(s) > 0 && !(gap_en && $urandom_range(0, 3) == 0)) begin
                b                  = qhead(s);
                src_valid[s]       = 1'b1;
                src_data[8*s +: 8] = b.d;
                src_sop[s]         = b.s;
                src_eop[s]         = b.e;
                pres[s]            = 1'b1;
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic mstate_t rst_state();
        mstate_t r;
        r = '{default: 0};
        r.ptr = N - 1;
        return r;
    endfunction

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    function automatic void model_eval(input mstate_t s, input int maxlen, output mexp_t e, output mstate_t n);
        int pick, nfl, cand;
        bit x, lim;
        e = '{default: '0};
        n = s;
        if (rst) begin
            n = rst_state();
            return;
        end
        if (!s.pkt && !s.drop) begin
            pick = -1;
            nfl  = 0;
            for (int k = 1; k <= N; k++) begin
                cand = (s.ptr + k) % N;
                if (pick < 0 && src_valid[cand] && src_sop[cand]) pick = cand;
            end
            for (int i = 0; i < N; i++) begin
                if (src_valid[i] && !src_sop[i]) begin
                    e.rdy[i] = 1'b1;
                    nfl++;
                end
            end
            n.flush = sat16(s.flush + nfl);
            if (pick >= 0) begin
                n.pkt = 1; n.g = pick; n.ptr = pick; n.gid = pick; n.cnt = 0;
            end
        end else if (s.pkt) begin
            x   = src_valid[s.g] && mac_rdy;
            lim = (s.cnt + 1 == maxlen) && !src_eop[s.g];
            e.rdy[s.g] = mac_rdy;
            e.data = src_data[8*s.g +: 8];
            e.sop  = src_sop[s.g];
            e.eop  = src_eop[s.g] | (x & lim);
            e.err  = x & lim;
            e.wren = x;
            if (x) begin
                n.cnt = s.cnt + 1;
                if (src_eop[s.g]) n.pkt = 0;
                else if (lim) begin
                    n.pkt = 0; n.drop = 1; n.trunc = sat16(s.trunc + 1);
                end
            end
        end else begin
            e.rdy[s.g] = 1'b1;
            if (src_valid[s.g] && src_eop[s.g]) n.drop = 0;
        end
    endfunction

    task automatic cmp_all(input string p, input mexp_t e, input mstate_t s,
                           input logic [N-1:0] rdy, input logic [7:0] d, input logic sop,
                           input logic eop, input logic err, input logic wren, input logic [1:0] gid,
                           input logic bsy, input logic [15:0] tc, input logic [15:0] fc);
        chk({p, "src_rdy"}, 32'(rdy), 32'(e.rdy));
        chk({p, "mac_data"}, 32'(d), 32'(e.data));
        chk({p, "mac_sop"}, 32'(sop), 32'(e.sop));
        chk({p, "mac_eop"}, 32'(eop), 32'(e.eop));
        chk({p, "mac_err"}, 32'(err), 32'(e.err));
        chk({p, "mac_wren"}, 32'(wren), 32'(e.wren));
        chk({p, "grant_id"}, 32'(gid), 32'(s.gid));
        chk({p, "busy"}, 32'(bsy), 32'(s.pkt | s.drop));
        chk({p, "trunc_count"}, 32'(tc), 32'(s.trunc));
        chk({p, "flush_count"}, 32'(fc), 32'(s.flush));
    endtask

    // ---------------- monitor / compare ----------------
    bit      chk_en = 1'b0;
    mstate_t ma, mb;
    beat_t   outq[$];
    int      sop_src[$];
    int      a_wren_n = 0, b_wren_n = 0, b_drain_n = 0;
    logic    b_last_eop = 1'b0, b_last_err = 1'b0;

    always @(negedge tx_clk) begin
        mexp_t ea, eb;
        mstate_t na, nb;
        if (chk_en) begin
            model_eval(ma, MAXA, ea, na);
            model_eval(mb, MAXB, eb, nb);
            cmp_all("a.", ea, ma, a_src_rdy, a_mac_data, a_mac_sop, a_mac_eop, a_mac_err,
                    a_mac_wren, a_grant_id, a_busy, a_trunc, a_flush);
            cmp_all("b.", eb, mb, b_src_rdy, b_mac_data, b_mac_sop, b_mac_eop, b_mac_err,
                    b_mac_wren, b_grant_id, b_busy, b_trunc, b_flush);
            ma = na;
            mb = nb;
        end else if (rst) begin
            chk_en = 1'b1;
            ma = rst_state();
            mb = rst_state();
        end
        if (a_mac_wren === 1'b1) begin
            a_wren_n++;
            outq.push_back('{d: a_mac_data, s: a_mac_sop, e: a_mac_eop});
            if (a_mac_sop) sop_src.push_back(int'(a_grant_id));
        end
        if (b_mac_wren === 1'b1) begin
            b_wren_n++;
            b_last_eop = b_mac_eop;
            b_last_err = b_mac_err;
        end
        if (b_busy && !b_mac_wren && |(b_src_rdy & src_valid)) b_drain_n++;
        cons = src_valid & a_src_rdy;
    end

    // ---------------- directed sequence ----------------
    task automatic cyc();
        @(posedge tx_clk);
        #2;
    endtask

    task automatic clear_stats();
        outq.delete();
        sop_src.delete();
        a_wren_n = 0; b_wren_n = 0; b_drain_n = 0;
        b_last_eop = 1'b0; b_last_err = 1'b0;
    endtask

    task automatic do_reset();
        rst_req = 1'b1;
        q0.delete(); q1.delete();
        stray_mask = '0; rdy_mode = 0; gap_en = 1'b0;
        cyc(); cyc();
        rst_req = 1'b0;
        cyc(); cyc();
        clear_stats();
    endtask

    task automatic push_pkt(input int s, input int len, input logic [7:0] base, input int nstray);
        for (int k = 0; k < nstray; k++) qpush(s, '{d: 8'($urandom), s: 1'b0, e: 1'b0});
        for (int k = 0; k < len; k++) qpush(s, '{d: base + 8'(k), s: (k == 0), e: (k == len - 1)});
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            if (q0.size() == 0 && q1.size() == 0 && !a_busy) done = 1'b1;
            else cyc();
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: got busy after %0d cycles, expected idle", name, budget);
        end
        cyc();
    endtask

    initial begin
        logic [7:0] exp_d;
        int idx, len, s;

        repeat (3) cyc();
        rst_req = 1'b0;
        cyc(); cyc();
        clear_stats();

        // Mid-packet reset: abandon src 1 packet, outputs clear, next grant goes to src 0
        push_pkt(1, 10, 8'hA0, 0);
        repeat (4) cyc();
        chk("pre_rst_busy", 32'(a_busy), 32'd1);
        chk("pre_rst_grant", 32'(a_grant_id), 32'd1);
        rst_req = 1'b1;
        q0.delete(); q1.delete();
        cyc(); cyc();
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_grant", 32'(a_grant_id), 32'd0);
        chk("rst_wren", 32'(a_mac_wren), 32'd0);
        chk("rst_src_rdy", 32'(a_src_rdy), 32'd0);
        chk("rst_eop", 32'(a_mac_eop), 32'd0);
        rst_req = 1'b0;
        cyc(); cyc();
        clear_stats();
        push_pkt(0, 2, 8'h01, 0);
        push_pkt(1, 2, 8'h11, 0);
        wait_idle("post_rst", 200);
        chk("post_rst_n", 32'(sop_src.size()), 32'd2);
        if (sop_src.size() >= 2) begin
            chk("post_rst_first", 32'(sop_src[0]), 32'd0);
            chk("post_rst_second", 32'(sop_src[1]), 32'd1);
        end

        // Round robin: 3 packets of 4 bytes per source
        do_reset();
        for (int p = 0; p < 3; p++) begin
            push_pkt(0, 4, 8'(p * 16), 0);
            push_pkt(1, 4, 8'(64 + p * 16), 0);
        end
        wait_idle("rr", 500);
        chk("rr_pkts", 32'(sop_src.size()), 32'd6);
        for (int i = 0; i < 6 && i < sop_src.size(); i++) chk("rr_order", 32'(sop_src[i]), 32'(i % 2));
        chk("rr_bytes", 32'(outq.size()), 32'd24);
        idx = 0;
        for (int p = 0; p < 3; p++) begin
            for (int sr = 0; sr < 2; sr++) begin
                for (int k = 0; k < 4; k++) begin
                    exp_d = 8'(sr * 64 + p * 16 + k);
                    if (idx < outq.size())
                        chk("rr_beat", 32'(outq[idx]), 32'({exp_d, (k == 0), (k == 3)}));
                    idx++;
                end
            end
        end

        // Truncation: 20-byte packet on src 1; instance b limits to 16 bytes
        do_reset();
        push_pkt(1, 20, 8'h40, 0);
        wait_idle("trunc", 500);
        chk("trunc_a_wren", 32'(a_wren_n), 32'd20);
        chk("trunc_a_count", 32'(a_trunc), 32'd0);
        chk("trunc_b_wren", 32'(b_wren_n), 32'd16);
        chk("trunc_b_eop", 32'(b_last_eop), 32'd1);
        chk("trunc_b_err", 32'(b_last_err), 32'd1);
        chk("trunc_b_drained", 32'(b_drain_n), 32'd4);
        chk("trunc_b_count", 32'(b_trunc), 32'd1);

        // 64-byte packet with mac_rdy toggling every cycle
        do_reset();
        rdy_mode = 1;
        push_pkt(0, 64, 8'h80, 0);
        wait_idle("toggle", 1000);
        chk("toggle_wren", 32'(a_wren_n), 32'd64);
        for (int k = 0; k < 64 && k < outq.size(); k++)
            chk("toggle_data", 32'(outq[k]), 32'({8'(8'h80 + k), (k == 0), (k == 63)}));

        // Stray bytes ahead of a packet are flushed; packet forwarded whole
        do_reset();
        push_pkt(0, 5, 8'h30, 3);
        wait_idle("flush", 500);
        chk("flush_count", 32'(a_flush), 32'd3);
        chk("flush_wren", 32'(a_wren_n), 32'd5);
        if (outq.size() > 0) chk("flush_first", 32'(outq[0]), 32'({8'h30, 1'b1, 1'b0}));

        // Randomised traffic on both sources
        do_reset();
        rdy_mode = 2;
        gap_en = 1'b1;
        for (int p = 0; p < 40; p++) begin
            s   = int'($urandom_range(0, N - 1));
            len = int'($urandom_range(1, 24));
            push_pkt(s, len, 8'($urandom), int'($urandom_range(0, 3) == 0 ? $urandom_range(1, 2) : 0));
        end
        wait_idle("random", 20000);

        // Flush counter saturation
        do_reset();
        stray_mask = 2'b11;
        cyc();
        repeat (32767) cyc();
        chk("sat_fffe", 32'(a_flush), 32'h0000_FFFE);
        stray_mask = 2'b01;
        cyc(); cyc();
        stray_mask = 2'b00;
        cyc(); cyc();
        chk("sat_ffff", 32'(a_flush), 32'h0000_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
